// File: rtl/pr_score_responder.sv
// PageRank score responder: local score table plus a request FIFO that serves
// score lookups to the responder NoC, with same-cycle update bypass.
module pr_score_responder #(
  parameter int WIDTH = 16,
  parameter int ADDWIDTH = 4,
  parameter int PORTW = 2,
  parameter int FIFO_AW = 2,
  parameter logic [WIDTH-1:0] RESET_SCORE = 16'h4000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH+ADDWIDTH:0]       score_in,
  input  logic [ADDWIDTH+2*PORTW:0]     req_in,
  output logic                          req_ready,
  input  logic                          full,
  input  logic                          almost_full,
  output logic [WIDTH+2*PORTW:0]        data_out,
  output logic                          write,
  output logic [7:0]                    drop_cnt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int NODES = 2 ** ADDWIDTH;
  localparam int EW    = ADDWIDTH + 2 * PORTW;

  logic [WIDTH-1:0]    score_tbl [NODES];
  logic [EW-1:0]       fifo_mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    count;

  logic                upd_valid;
  logic [ADDWIDTH-1:0] upd_idx;
  logic [WIDTH-1:0]    upd_score;
  logic                req_valid;
  logic [EW-1:0]       req_entry;
  logic [EW-1:0]       head;
  logic [ADDWIDTH-1:0] head_idx;
  logic [PORTW-1:0]    head_dst, head_src;
  logic [WIDTH-1:0]    sel_score;
  logic                fifo_full, fifo_empty, can_send, push, pop;

  assign upd_valid = score_in[0];
  assign upd_idx   = score_in[ADDWIDTH:1];
  assign upd_score = score_in[WIDTH+ADDWIDTH:ADDWIDTH+1];
  assign req_valid = req_in[0];
  assign req_entry = req_in[EW:1];

  assign head     = fifo_mem[rd_ptr];
  assign head_src = head[PORTW-1:0];
  assign head_dst = head[2*PORTW-1:PORTW];
  assign head_idx = head[EW-1:2*PORTW];

  // Occupancy never exceeds DEPTH, so the MSB alone flags full.
  assign fifo_full  = count[FIFO_AW];
  assign fifo_empty = (count == '0);
  assign req_ready  = ~fifo_full;

  // After a push the NoC may only have one slot left, so almost_full governs.
  assign can_send = write ? ~almost_full : ~full;
  assign push     = req_valid & ~fifo_full;
  assign pop      = ~fifo_empty & can_send;

  assign sel_score = (upd_valid && (upd_idx == head_idx)) ? upd_score : score_tbl[head_idx];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NODES; i++) score_tbl[i] <= RESET_SCORE;
    end else if (upd_valid) begin
      score_tbl[upd_idx] <= upd_score;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      write    <= 1'b0;
      data_out <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      write <= pop;
      if (pop) data_out <= {sel_score, head_src, head_dst, 1'b1};
      if (req_valid && fifo_full && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pr_score_responder.sv
// Bench for pr_score_responder: directed vector table, readback, drop
// saturation and randomized traffic against a queue-based reference model.
module tb_pr_score_responder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] score_in;
  logic [8:0]  req_in;
  logic        req_ready;
  logic        full, almost_full;
  logic [20:0] data_out;
  logic        write;
  logic [7:0]  drop_cnt;

  pr_score_responder dut (
    .clk(clk), .reset(reset), .score_in(score_in), .req_in(req_in),
    .req_ready(req_ready), .full(full), .almost_full(almost_full),
    .data_out(data_out), .write(write), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit sv; logic [3:0] sidx; logic [15:0] ss;
    bit rv; logic [3:0] ridx; logic [1:0] rdst; logic [1:0] rsrc;
    bit full; bit af;
    bit chkr; bit er; bit ew; logic [20:0] ed; logic [7:0] edrop;
  } vec_t;

  typedef struct { logic [3:0] idx; logic [1:0] dst; logic [1:0] src; } req_t;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic [15:0] m_scores [16];
  req_t        m_q [$];
  bit          m_write;
  logic [20:0] m_data;
  int          m_drop;
  bit          m_init = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] D(input logic [15:0] s, input logic [1:0] src, input logic [1:0] dst);
    return {s, src, dst, 1'b1};
  endfunction

  function automatic vec_t V(input bit rst, input bit sv, input logic [3:0] sidx, input logic [15:0] ss,
                             input bit rv, input logic [3:0] ridx, input logic [1:0] rdst, input logic [1:0] rsrc,
                             input bit fl, input bit af, input bit chkr, input bit er, input bit ew,
                             input logic [20:0] ed, input logic [7:0] edrop);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sidx = sidx; v.ss = ss;
    v.rv = rv; v.ridx = ridx; v.rdst = rdst; v.rsrc = rsrc;
    v.full = fl; v.af = af; v.chkr = chkr; v.er = er; v.ew = ew; v.ed = ed; v.edrop = edrop;
    return v;
  endfunction

  function automatic vec_t idle(input bit fl, input bit af);
    return V(0, 0, 0, 0, 0, 0, 0, 0, fl, af, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t rq(input logic [3:0] idx, input logic [1:0] dst, input logic [1:0] src, input bit fl);
    return V(0, 0, 0, 0, 1, idx, dst, src, fl, 0, 0, 0, 0, 0, 0);
  endfunction

  // One clock edge of the reference behaviour, from the pre-edge inputs.
  task automatic model_edge(input vec_t v);
    bit ready, can_send;
    req_t h;
    logic [15:0] sc;
    if (v.rst) begin
      for (int i = 0; i < 16; i++) m_scores[i] = 16'h4000;
      m_q.delete();
      m_write = 0; m_data = '0; m_drop = 0; m_init = 1;
    end else begin
      ready = (m_q.size() < DEPTH);
      can_send = m_write ? !v.af : !v.full;
      if (m_q.size() > 0 && can_send) begin
        h = m_q.pop_front();
        sc = (v.sv && v.sidx == h.idx) ? v.ss : m_scores[h.idx];
        m_data = {sc, h.src, h.dst, 1'b1};
        m_write = 1;
      end else begin
        m_write = 0;
      end
      if (v.rv) begin
        if (ready) begin
          h.idx = v.ridx; h.dst = v.rdst; h.src = v.rsrc;
          m_q.push_back(h);
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      if (v.sv) m_scores[v.sidx] = v.ss;
    end
  endtask

  task automatic step(input vec_t v, input bit use_exp, input int id);
    @(negedge clk);
    reset = v.rst;
    score_in = {v.ss, v.sidx, v.sv};
    req_in = {v.ridx, v.rdst, v.rsrc, v.rv};
    full = v.full;
    almost_full = v.af;
    #1;
    if (m_init) chk("model req_ready", {31'd0, req_ready}, {31'd0, (m_q.size() < DEPTH)});
    if (use_exp && v.chkr) chk($sformatf("vec%0d req_ready", id), {31'd0, req_ready}, {31'd0, v.er});
    @(posedge clk);
    model_edge(v);
    #1;
    if (m_init) begin
      chk("model write", {31'd0, write}, {31'd0, m_write});
      chk("model data_out", {11'd0, data_out}, {11'd0, m_data});
      chk("model drop_cnt", {24'd0, drop_cnt}, m_drop);
    end
    if (use_exp) begin
      chk($sformatf("vec%0d write", id), {31'd0, write}, {31'd0, v.ew});
      chk($sformatf("vec%0d data_out", id), {11'd0, data_out}, {11'd0, v.ed});
      chk($sformatf("vec%0d drop_cnt", id), {24'd0, drop_cnt}, {24'd0, v.edrop});
    end
  endtask

  vec_t vq [$];
  vec_t rv_t;
  int   nresp;

  initial begin
    reset = 1; score_in = '0; req_in = '0; full = 0; almost_full = 0;

    // rst sv sidx ss  rv ridx dst src full af  chkr er ew data drop
    vq.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vq.push_back(V(0, 0, 0, 0, 1, 3, 2, 1, 0, 0, 1, 1, 0, 0, 0));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, D(16'h4000, 1, 2), 0));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, D(16'h4000, 1, 2), 0));
    vq.push_back(V(0, 1, 5, 16'h1234, 1, 5, 3, 0, 0, 0, 1, 1, 0, D(16'h4000, 1, 2), 0));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, D(16'h1234, 0, 3), 0));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, D(16'h1234, 0, 3), 0));
    vq.push_back(V(0, 0, 0, 0, 1, 5, 1, 2, 1, 0, 1, 1, 0, D(16'h1234, 0, 3), 0));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, D(16'h1234, 0, 3), 0));
    vq.push_back(V(0, 1, 5, 16'h2222, 0, 0, 0, 0, 0, 0, 1, 1, 1, D(16'h2222, 2, 1), 0));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, D(16'h2222, 2, 1), 0));
    vq.push_back(V(0, 0, 0, 0, 1, 5, 3, 0, 1, 0, 1, 1, 0, D(16'h2222, 2, 1), 0));
    vq.push_back(V(0, 0, 0, 0, 1, 1, 2, 1, 1, 0, 1, 1, 0, D(16'h2222, 2, 1), 0));
    vq.push_back(V(0, 0, 0, 0, 1, 2, 1, 2, 1, 0, 1, 1, 0, D(16'h2222, 2, 1), 0));
    vq.push_back(V(0, 0, 0, 0, 1, 3, 0, 3, 1, 0, 1, 1, 0, D(16'h2222, 2, 1), 0));
    vq.push_back(V(0, 0, 0, 0, 1, 4, 0, 0, 1, 0, 1, 0, 0, D(16'h2222, 2, 1), 1));
    vq.push_back(V(0, 0, 0, 0, 1, 6, 1, 1, 1, 0, 1, 0, 0, D(16'h2222, 2, 1), 2));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, D(16'h2222, 0, 3), 2));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, D(16'h4000, 1, 2), 2));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, D(16'h4000, 2, 1), 2));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, D(16'h4000, 3, 0), 2));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, D(16'h4000, 3, 0), 2));
    vq.push_back(V(0, 0, 0, 0, 1, 7, 1, 1, 0, 0, 1, 1, 0, D(16'h4000, 3, 0), 2));
    vq.push_back(V(0, 0, 0, 0, 1, 8, 2, 2, 0, 0, 1, 1, 1, D(16'h4000, 1, 1), 2));
    vq.push_back(V(0, 0, 0, 0, 1, 9, 3, 3, 0, 1, 1, 1, 0, D(16'h4000, 1, 1), 2));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, D(16'h4000, 2, 2), 2));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, D(16'h4000, 3, 3), 2));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, D(16'h4000, 3, 3), 2));
    vq.push_back(V(0, 0, 0, 0, 1, 10, 1, 0, 1, 0, 1, 1, 0, D(16'h4000, 3, 3), 2));
    vq.push_back(V(0, 0, 0, 0, 1, 11, 0, 1, 1, 0, 1, 1, 0, D(16'h4000, 3, 3), 2));
    vq.push_back(V(0, 0, 0, 0, 1, 12, 2, 2, 1, 0, 1, 1, 0, D(16'h4000, 3, 3), 2));
    vq.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));

    foreach (vq[i]) step(vq[i], 1, i);

    // Every entry must read back as the reset score after the reset above.
    nresp = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) rv_t = rq(i[3:0], i[1:0], 2'(3 - i % 4), 0);
      else rv_t = idle(0, 0);
      step(rv_t, 0, 0);
      if (write === 1'b1) begin
        chk("readback score", {16'd0, data_out[20:5]}, 32'h4000);
        nresp++;
      end
    end
    chk("readback count", nresp, 16);

    // Drop counter saturates at 255 while the FIFO is held full.
    for (int i = 0; i < 262; i++) step(rq(4'(i), 2'(i), 2'(i >> 2), 1), 0, 0);
    chk("drop saturation", {24'd0, drop_cnt}, 255);
    step(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);

    for (int i = 0; i < 3000; i++) begin
      rv_t = V($urandom_range(0, 299) == 0, $urandom_range(0, 1), 4'($urandom), 16'($urandom),
               $urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), 2'($urandom),
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 0, 0, 0, 0, 0);
      step(rv_t, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
